// File: rtl/regfile_pkg.sv
// Shared constants, types and reset-value helper for the decode-stage register file.
// Latency: none (compile-time definitions only).
// Backpressure: not applicable.
package regfile_pkg;

    localparam int N        = 64;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int ZERO_REG = NREG - 1;
    localparam int IRQ_REG  = NREG - 3;
    localparam int INV_REG  = NREG - 2;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [N-1:0]  word_t;

    // Registers come out of reset holding their own index; the zero register
    // and both exception counters start at zero.
    function automatic word_t reset_value(input int idx,
                                          input int zero_reg = ZERO_REG,
                                          input int irq_reg  = IRQ_REG,
                                          input int inv_reg  = INV_REG);
        if (idx == zero_reg || idx == irq_reg || idx == inv_reg) begin
            return '0;
        end
        return word_t'(idx);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, read-port busy flags and issue stall.
// Latency: rd_busy/stall combinational; set/clear take effect on the next clock edge.
// Backpressure: stall suppresses the busy-bit set of the instruction attempting issue.
module regfile_sb_scoreboard #(
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = NREG - 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NRD-1:0][AW-1:0]  ra,
    input  logic                    we3,
    input  logic [AW-1:0]           wa3,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_wa,
    output logic [NRD-1:0]          rd_busy,
    output logic                    stall
);

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Per-port busy lookup and the combined stall decision.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = busy_q[ra[k]] && (ra[k] != ZERO_A);
`ifdef REGFILE_BYPASS_EN
            // A writeback landing this cycle already satisfies the reader.
            if (we3 && (wa3 == ra[k])) begin
                rd_busy[k] = 1'b0;
            end
`endif
        end
        stall = (|rd_busy) || (iss_valid && busy_q[iss_wa]);
    end

    // Writeback clears, then a successful issue sets, so a new producer wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (we3) begin
            busy_d[wa3] = 1'b0;
        end
        if (iss_valid && !stall && (iss_wa != ZERO_A)) begin
            busy_d[iss_wa] = 1'b1;
        end
    end

    // Busy-bit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: NRD combinational read ports, one writeback port, zero reg, exception counters.
// Latency: reads 0 cycles; writes visible next cycle (same cycle with REGFILE_BYPASS_EN defined).
// Backpressure: stall output when a source or the issuing destination has a pending write.
module regfile_sb #(
    parameter int N        = regfile_pkg::N,
    parameter int NREG     = regfile_pkg::NREG,
    parameter int NRD      = 2,
    parameter int ZERO_REG = NREG - 1,
    parameter int IRQ_REG  = NREG - 3,
    parameter int INV_REG  = NREG - 2,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NRD-1:0][AW-1:0]  ra,
    output logic [NRD-1:0][N-1:0]   rd,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    we3,
    input  logic [AW-1:0]           wa3,
    input  logic [N-1:0]            wd3,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_wa,
    output logic                    stall,
    input  logic                    exc_irq,
    input  logic                    exc_invop
);

    import regfile_pkg::*;

    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [N-1:0] regs_q [NREG];
    logic [N-1:0] regs_d [NREG];

    regfile_sb_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra        (ra),
        .we3       (we3),
        .wa3       (wa3),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .rd_busy   (rd_busy),
        .stall     (stall)
    );

    // Next register state: writeback first, then counters increment on top of
    // whatever the writeback left, so a same-cycle write and pulse both count.
    always_comb begin
        regs_d = regs_q;
        if (we3 && (wa3 != ZERO_A)) begin
            regs_d[wa3] = wd3;
        end
        if (exc_irq) begin
            regs_d[IRQ_REG] = regs_d[IRQ_REG] + N'(1);
        end
        if (exc_invop) begin
            regs_d[INV_REG] = regs_d[INV_REG] + N'(1);
        end
    end

    // Read ports: zero register hardwired, otherwise stored (or forwarded) value.
    always_comb begin
        rd = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ra[k] != ZERO_A) begin
                rd[k] = regs_q[ra[k]];
`ifdef REGFILE_BYPASS_EN
                // Forward the post-write (and post-increment) value.
                if (we3 && (wa3 == ra[k])) begin
                    rd[k] = regs_d[ra[k]];
                end
`endif
            end
        end
    end

    // Register storage with synchronous reset to the per-index reset values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= N'(reset_value(i, ZERO_REG, IRQ_REG, INV_REG));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb (default parameters, NRD = 2).
// Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
// Expected values are hand-derived; bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [63:0] ONES = {64{1'b1}};

    logic              clk;
    logic              reset_n;
    logic [1:0][4:0]   ra;
    logic [1:0][63:0]  rd;
    logic [1:0]        rd_busy;
    logic              we3;
    logic [4:0]        wa3;
    logic [63:0]       wd3;
    logic              iss_valid;
    logic [4:0]        iss_wa;
    logic              stall;
    logic              exc_irq;
    logic              exc_invop;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst_n;
        logic [4:0]  ra0, ra1;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  iwa;
        logic        irq, inv;
        logic        chk;
        logic [63:0] e0, e1;
        logic [1:0]  eb;
        logic        es;
    } vec_t;

    vec_t vt[$];

    regfile_sb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .stall     (stall),
        .exc_irq   (exc_irq),
        .exc_invop (exc_invop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_n, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                input logic iv, input logic [4:0] iwa,
                                input logic irq, input logic inv, input logic chk,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic [1:0] eb, input logic es);
        vec_t v;
        v.rst_n = rst_n; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd;
        v.iv = iv; v.iwa = iwa; v.irq = irq; v.inv = inv; v.chk = chk;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one vector on the falling edge, sample outputs shortly after.
    task automatic run(input vec_t v, input string tag);
        @(negedge clk);
        reset_n   = v.rst_n;
        ra[0]     = v.ra0;
        ra[1]     = v.ra1;
        we3       = v.we;
        wa3       = v.wa;
        wd3       = v.wd;
        iss_valid = v.iv;
        iss_wa    = v.iwa;
        exc_irq   = v.irq;
        exc_invop = v.inv;
        #2;
        if (v.chk) begin
            check({tag, " rd0"}, rd[0], v.e0);
            check({tag, " rd1"}, rd[1], v.e1);
            check({tag, " rd_busy"}, 64'(rd_busy), 64'(v.eb));
            check({tag, " stall"}, 64'(stall), 64'(v.es));
        end
    endtask

    initial begin
        reset_n = 1'b0; ra = '0; we3 = 1'b0; wa3 = '0; wd3 = '0;
        iss_valid = 1'b0; iss_wa = '0; exc_irq = 1'b0; exc_invop = 1'b0;

        //            rst ra0 ra1 we wa  wd             iv iwa irq inv chk e0                        e1                     eb     es
        vt.push_back(mk(0, 0,  0,  0, 0,  0,             0, 0,  0,  0,  0,  0,                        0,                     2'b00, 0));  // 0 reset
        vt.push_back(mk(1, 5,  31, 0, 0,  0,             0, 0,  0,  0,  1,  5,                        0,                     2'b00, 0));  // 1
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  0,  0,  1,  0,                        0,                     2'b00, 0));  // 2
        vt.push_back(mk(1, 7,  31, 1, 31, 64'hDEAD,      0, 0,  0,  0,  1,  7,                        0,                     2'b00, 0));  // 3 write zero reg
        vt.push_back(mk(1, 31, 7,  1, 7,  64'hABCD,      0, 0,  0,  0,  1,  0,  BYP ? 64'hABCD : 64'd7,                       2'b00, 0));  // 4
        vt.push_back(mk(1, 7,  31, 0, 0,  0,             0, 0,  0,  0,  1,  64'hABCD,                 0,                     2'b00, 0));  // 5
        vt.push_back(mk(1, 1,  2,  0, 0,  0,             1, 9,  0,  0,  1,  1,                        2,                     2'b00, 0));  // 6 issue x9
        vt.push_back(mk(1, 9,  2,  0, 0,  0,             1, 3,  0,  0,  1,  9,                        2,                     2'b01, 1));  // 7 stalled issue x3
        vt.push_back(mk(1, 3,  9,  0, 0,  0,             0, 0,  0,  0,  1,  3,                        9,                     2'b10, 1));  // 8
        vt.push_back(mk(1, 3,  9,  1, 9,  64'h99,        0, 0,  0,  0,  1,  3,  BYP ? 64'h99 : 64'd9,  BYP ? 2'b00 : 2'b10, !BYP)); // 9
        vt.push_back(mk(1, 9,  3,  0, 0,  0,             0, 0,  0,  0,  1,  64'h99,                   3,                     2'b00, 0));  // 10
        vt.push_back(mk(1, 1,  2,  1, 4,  64'h44,        1, 4,  0,  0,  1,  1,                        2,                     2'b00, 0));  // 11 set beats clear
        vt.push_back(mk(1, 4,  1,  0, 0,  0,             0, 0,  0,  0,  1,  64'h44,                   1,                     2'b01, 1));  // 12
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  1,  0,  1,  0,                        0,                     2'b00, 0));  // 13 irq
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  1,  0,  1,  1,                        0,                     2'b00, 0));  // 14 irq
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  1,  0,  1,  2,                        0,                     2'b00, 0));  // 15 irq
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  0,  0,  1,  3,                        0,                     2'b00, 0));  // 16
        vt.push_back(mk(1, 29, 30, 1, 29, 100,           0, 0,  1,  0,  1,  BYP ? 64'd101 : 64'd3,    0,                     2'b00, 0));  // 17 write+irq
        vt.push_back(mk(1, 29, 1,  0, 0,  0,             0, 0,  0,  0,  1,  101,                      1,                     2'b00, 0));  // 18
        vt.push_back(mk(1, 30, 29, 1, 30, ONES,          0, 0,  0,  0,  1,  BYP ? ONES : 64'd0,       101,                   2'b00, 0));  // 19
        vt.push_back(mk(1, 30, 29, 0, 0,  0,             0, 0,  0,  1,  1,  ONES,                     101,                   2'b00, 0));  // 20 invop wrap
        vt.push_back(mk(1, 30, 29, 0, 0,  0,             0, 0,  0,  0,  1,  0,                        101,                   2'b00, 0));  // 21
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  1,  1,  1,  101,                      0,                     2'b00, 0));  // 22 both pulses
        vt.push_back(mk(1, 29, 30, 0, 0,  0,             0, 0,  0,  0,  1,  102,                      1,                     2'b00, 0));  // 23
        vt.push_back(mk(0, 4,  29, 1, 5,  64'h555,       1, 6,  1,  1,  0,  0,                        0,                     2'b00, 0));  // 24 reset mid-stream
        vt.push_back(mk(1, 4,  29, 0, 0,  0,             0, 0,  0,  0,  1,  4,                        0,                     2'b00, 0));  // 25
        vt.push_back(mk(1, 30, 5,  0, 0,  0,             0, 0,  0,  0,  1,  0,                        5,                     2'b00, 0));  // 26
        vt.push_back(mk(1, 7,  9,  0, 0,  0,             0, 0,  0,  0,  1,  7,                        9,                     2'b00, 0));  // 27

        for (int i = 0; i < vt.size(); i++) begin
            run(vt[i], $sformatf("vec%0d", i));
        end

        // Destination-busy stall and duplicate read ports on a busy register.
        run(mk(1, 12, 12, 0, 0,  0,       1, 12, 0, 0, 1, 12,      12,      2'b00, 0), "seq_issue12");
        run(mk(1, 0,  1,  0, 0,  0,       1, 12, 0, 0, 1, 0,       1,       2'b00, 1), "seq_dest_busy");
        run(mk(1, 12, 12, 0, 0,  0,       0, 0,  0, 0, 1, 12,      12,      2'b11, 1), "seq_dup_busy");
        run(mk(1, 0,  1,  1, 12, 64'h1212, 1, 12, 0, 0, 1, 0,       1,       2'b00, 1), "seq_wb_stalled_issue");
        run(mk(1, 12, 12, 0, 0,  0,       0, 0,  0, 0, 1, 64'h1212, 64'h1212, 2'b00, 0), "seq_after_wb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
